// File: rtl/mult_div_unit.sv
// mult_div_unit: 33-cycle radix-2 multiply/divide with HI/LO registers.
// Optional MTHI/MTLO write port enabled by MDU_HILO_WRITE_EN.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rs_out,
  input  logic [31:0] alu_b,
  input  logic        start,
  input  logic [1:0]  op,
`ifdef MDU_HILO_WRITE_EN
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;

  logic        is_div;
  logic        sgn;
  logic        sa;
  logic        sb;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [32:0] sum;
  logic [32:0] shl;
  logic [31:0] diff;
  logic        ge;
  logic [31:0] nx_hi;
  logic [31:0] nx_lo;
  logic [63:0] prod;
  logic [63:0] prod_n;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        s
  );
    return (s && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // op[0] low selects the signed flavour, op[1] high selects divide
  assign is_div = op_q[1];
  assign sgn    = ~op_q[0];
  assign sa     = sgn & a_q[31];
  assign sb     = sgn & b_q[31];
  assign ma     = mag(a_q, sgn);
  assign mb     = mag(b_q, sgn);
  assign busy   = (state_q != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state: 32 RUN cycles counted by the wrapping 5-bit counter
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // one radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, ma} : 33'd0);
    shl  = {acc_hi, acc_lo[31]};
    ge   = (shl >= {1'b0, mb});
    diff = shl[31:0] - mb;
    if (is_div) begin
      nx_hi = ge ? diff : shl[31:0];
      nx_lo = {acc_lo[30:0], ge};
    end else begin
      nx_hi = sum[32:1];
      nx_lo = {sum[0], acc_lo[31:1]};
    end
  end

  // sign fix-up of the unsigned magnitude result
  always_comb begin
    prod   = {acc_hi, acc_lo};
    prod_n = ~prod + 64'd1;
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (!is_div) begin
      {res_hi, res_lo} = (sa ^ sb) ? prod_n : prod;
    end else if (b_q == 32'd0) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_lo = (sa ^ sb) ? (~acc_lo + 32'd1) : acc_lo;
      res_hi = sa ? (~acc_hi + 32'd1) : acc_hi;
    end
  end

  // operand latch, iteration datapath and HI/LO write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      op_q   <= 2'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= rs_out;
            b_q    <= alu_b;
            op_q   <= op;
            cnt    <= 5'd0;
            acc_hi <= 32'd0;
            acc_lo <= op[1] ? mag(rs_out, ~op[0])
                            : mag(alu_b, ~op[0]);
          end
`ifdef MDU_HILO_WRITE_EN
          else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
`endif
        end
        RUN: begin
          cnt    <= cnt + 5'd1;
          acc_hi <= nx_hi;
          acc_lo <= nx_lo;
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, corner sequences and random ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rs_out = 32'd0;
  logic [31:0] alu_b = 32'd0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
`ifdef MDU_HILO_WRITE_EN
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
`endif

  int vectors = 0;
  int miscompares = 0;

  mult_div_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rs_out (rs_out),
    .alu_b  (alu_b),
    .start  (start),
    .op     (op),
`ifdef MDU_HILO_WRITE_EN
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
`endif
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {hi,lo} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0]  o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 64'd0;
    if (o == 2'b00) begin
      r = sa * sb;
    end else if (o == 2'b01) begin
      r = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (o == 2'b10) begin
      q = sa / sb;
      m = sa % sb;
      r = {m[31:0], q[31:0]};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  task automatic run_check(input string nm,
                           input logic [1:0]  o,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [31:0] eh,
                           input logic [31:0] el);
    logic [31:0] ph;
    logic [31:0] pl;
    int lat;
    int bcnt;
    bit hold_bad;
    @(negedge clk);
    ph = hi;
    pl = lo;
    start = 1'b1;
    op = o;
    rs_out = a;
    alu_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom);
    rs_out = $urandom;
    alu_b = $urandom;
    lat = 0;
    bcnt = busy ? 1 : 0;
    hold_bad = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
      if (hi !== ph || lo !== pl) hold_bad = 1'b1;
    end
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    chk({nm, "_lat"}, 64'(lat), 64'd33);
    chk({nm, "_busy"}, 64'(bcnt), 64'd33);
    chk({nm, "_hold"}, 64'(hold_bad), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int nd;
    int d1;
    int d2;
    logic [31:0] gh;
    logic [31:0] gl;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] ex;

    vec[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vec[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vec[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vec[3]  = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vec[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vec[5]  = '{2'b11, 32'd1000,      32'd7,         32'd6,         32'd142};
    vec[6]  = '{2'b10, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vec[7]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vec[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vec[9]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vec[10] = '{2'b01, 32'h1234_5678, 32'd0,         32'd0,         32'd0};
    vec[11] = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};
    vec[12] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vec[13] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
    vec[14] = '{2'b11, 32'd5,         32'd10,        32'd5,         32'd0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_check($sformatf("vec%0d", i), vec[i].op, vec[i].a,
                vec[i].b, vec[i].eh, vec[i].el);
    end

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_out = 32'd1000; alu_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; gh = 32'd0; gl = 32'd0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 5 || c == 20) begin
        start = 1'b1; op = 2'b00; rs_out = $urandom; alu_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        nd++; gh = hi; gl = lo;
      end
    end
    start = 1'b0;
    chk("repulse_dones", 64'(nd), 64'd1);
    chk("repulse_lo", 64'(gl), 64'd142);
    chk("repulse_hi", 64'(gh), 64'd6);

    // reset mid-operation aborts with no done
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_out = 32'd5; alu_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_nodone", 64'(nd), 64'd0);
    run_check("after_rst", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

    // start held high relaunches at the first IDLE edge
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_out = 32'd1000; alu_b = 32'd7;
    d1 = -1; d2 = -1;
    for (int t = 0; t < 70; t++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) d1 = t;
        else if (d2 < 0) d2 = t;
      end
    end
    start = 1'b0;
    chk("held_done1", 64'(d1), 64'd33);
    chk("held_done2", 64'(d2), 64'd67);
    for (int c = 0; c < 80 && busy; c++) @(posedge clk);
    @(negedge clk);
    chk("held_drain", 64'(busy), 64'd0);

    // random operations against the model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = $urandom_range(0, 1000);
        default: ra = $urandom;
      endcase
      ex = model(ro, ra, rb);
      run_check($sformatf("rnd%0d", i), ro, ra, rb, ex[63:32], ex[31:0]);
    end

`ifdef MDU_HILO_WRITE_EN
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", 64'(lo), 64'h1234);
    hi_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", 64'(hi), 64'hABCD);
    start = 1'b1; op = 2'b01; rs_out = 32'd2; alu_b = 32'd3;
    hi_we = 1'b1; wdata = 32'h7777;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_start", 64'(hi), 64'hABCD);
    wdata = 32'h5555;
    repeat (5) @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_busy", 64'(hi), 64'hABCD);
    for (int c = 0; c < 60 && busy; c++) @(negedge clk);
    chk("mthi_res", 64'(lo), 64'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
